store_size_unit: RTL

STORE_SIZE_UNIT -- requirements
Module: store_size_unit

---
 rtl/store_size_unit.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/store_size_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// store_size_unit : sw/sh/sb store engine, read-modify-write for partial words.
// Revision: 1.0 -- initial release. Optional: STORE_ALIGN_CHECK_EN.
// ---------------------------------------------------------------------------
module store_size_unit #(
  parameter int MEM_RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  store_size_control,
  input  logic [31:0] store_addr,
  input  logic [31:0] b_input,
  input  logic [31:0] mem_data_in,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_data_out,
  output logic        busy,
  output logic        done,
  output logic        misaligned
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [2:0] WAIT_LAST = 3'(MEM_RD_LATENCY - 1);

  state_t      state;
  state_t      state_next;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] merge_q;
  logic [2:0]  wait_cnt;
  logic        req_is_sw;
  logic        req_fault;
  logic        wait_last;
  logic [31:0] merged;

  // 2'b11 is handled exactly like a full-word store.
  assign req_is_sw = ~(store_size_control[1] ^ store_size_control[0]);
  assign wait_last = (wait_cnt == WAIT_LAST);

`ifdef STORE_ALIGN_CHECK_EN
  logic misal_q;
  assign req_fault = (req_is_sw && (store_addr[1:0] != 2'b00)) ||
                     ((store_size_control == 2'b01) && store_addr[0]);
`else
  assign req_fault = 1'b0;
`endif

  // merge_q carries the register data until the memory word arrives.
  always_comb begin
    merged = merge_q;
    case (size_q)
      2'b01:   merged = {mem_data_in[31:16], merge_q[15:0]};
      2'b10:   merged = {mem_data_in[31:8],  merge_q[7:0]};
      default: merged = merge_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    busy         = (state != S_IDLE);
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    done         = 1'b0;
    mem_addr     = busy ? addr_q : 32'd0;
    mem_data_out = 32'd0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (req_fault)      state_next = S_DONE;
          else if (req_is_sw) state_next = S_WRITE;
          else                state_next = S_READ;
        end
      end
      S_READ: begin
        mem_rd     = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (wait_last) state_next = S_WRITE;
      end
      S_WRITE: begin
        mem_wr       = 1'b1;
        mem_data_out = merge_q;
        state_next   = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      size_q   <= 2'b00;
      addr_q   <= 32'd0;
      merge_q  <= 32'd0;
      wait_cnt <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            size_q  <= store_size_control;
            addr_q  <= store_addr;
            merge_q <= b_input;
          end
        end
        S_READ: wait_cnt <= 3'd0;
        S_WAIT: begin
          wait_cnt <= wait_cnt + 3'd1;
          if (wait_last) merge_q <= merged;
        end
        default: ;
      endcase
    end
  end

`ifdef STORE_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misal_q <= 1'b0;
    end else if (state == S_IDLE && start) begin
      misal_q <= req_fault;
    end
  end
  assign misaligned = (state == S_DONE) && misal_q;
`else
  assign misaligned = 1'b0;
`endif

endmodule
`default_nettype wire
